// File: rtl/gobang_pkg.sv
// Shared definitions for the gobang move-candidate generator: cell encoding,
// controller states and coordinate/size width helpers.
package gobang_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_OCC   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int coord_w(input int board_n);
        return (board_n <= 2) ? 1 : $clog2(board_n);
    endfunction

    function automatic int size_w(input int max_cand);
        return (max_cand <= 1) ? 1 : $clog2(max_cand + 1);
    endfunction

endpackage

// File: rtl/mcg_neighbor_check.sv
// Combinational candidacy test: the cell is empty and some non-empty cell lies
// within Chebyshev distance RADIUS, window clipped at the board edges.
module mcg_neighbor_check
    import gobang_pkg::*;
#(
    parameter int BOARD_N = 15,
    parameter int RADIUS  = 1,
    localparam int CW = coord_w(BOARD_N)
) (
    input  logic [2*BOARD_N*BOARD_N-1:0] i_board,
    input  logic [CW-1:0]                i_x,
    input  logic [CW-1:0]                i_y,
    output logic                         o_cand
);

    localparam int IW   = $clog2(2*BOARD_N*BOARD_N);
    localparam int SPAN = 2*RADIUS + 1;

    logic          w_near;
    logic          w_self_empty;
    logic [IW-1:0] w_self_idx;
    logic [IW-1:0] w_nidx;
    int            w_nx;
    int            w_ny;

    always_comb begin
        w_near       = 1'b0;
        w_nx         = 0;
        w_ny         = 0;
        w_nidx       = '0;
        w_self_idx   = IW'(2*(int'(i_y)*BOARD_N + int'(i_x)));
        w_self_empty = (i_board[w_self_idx +: 2] == CELL_EMPTY);
        // The centre cell is visited too; it only matters when the cell is
        // already occupied, and then the candidate flag is masked anyway.
        for (int unsigned j = 0; j < SPAN; j++) begin
            for (int unsigned i = 0; i < SPAN; i++) begin
                w_nx = int'(i_x) + int'(i) - RADIUS;
                w_ny = int'(i_y) + int'(j) - RADIUS;
                if (w_nx >= 0 && w_nx < BOARD_N && w_ny >= 0 && w_ny < BOARD_N) begin
                    w_nidx = IW'(2*(w_ny*BOARD_N + w_nx));
                    if (i_board[w_nidx +: 2] != CELL_EMPTY) begin
                        w_near = 1'b1;
                    end
                end
            end
        end
    end

    assign o_cand = w_self_empty && w_near;

endmodule

// File: rtl/move_candidate_gen.sv
// Scans a latched board in raster order, buffers neighbourhood candidates and
// drains them over a valid/ready handshake. Option: MCG_EMPTY_CENTER_EN.
module move_candidate_gen
    import gobang_pkg::*;
#(
    parameter int BOARD_N  = 15,
    parameter int RADIUS   = 1,
    parameter int MAX_CAND = 100,
    localparam int CW = coord_w(BOARD_N),
    localparam int SW = size_w(MAX_CAND)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [2*BOARD_N*BOARD_N-1:0] i_board,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [CW-1:0]                o_posX,
    output logic [CW-1:0]                o_posY,
    output logic                         o_last,
    output logic [SW-1:0]                o_size,
    output logic                         o_overflow,
    output logic                         o_busy,
    output logic                         o_finish
);

    localparam logic [CW-1:0] LAST_C = CW'(BOARD_N - 1);
    localparam logic [CW-1:0] CENTER = CW'(BOARD_N / 2);
    localparam logic [SW-1:0] MAX_S  = SW'(MAX_CAND);

    state_t                    r_state;
    logic [2*BOARD_N*BOARD_N-1:0] r_board;
    logic [CW-1:0]             r_x;
    logic [CW-1:0]             r_y;
    logic [SW-1:0]             r_size;
    logic [SW-1:0]             r_rd;
    logic                      r_overflow;
    logic                      r_valid;
    logic                      r_last;
    logic                      r_busy;
    logic                      r_finish;
    logic [CW-1:0]             r_posX;
    logic [CW-1:0]             r_posY;
    logic [CW-1:0]             r_buf_x [MAX_CAND];
    logic [CW-1:0]             r_buf_y [MAX_CAND];

    logic                      w_cand;
    logic                      w_last_cell;
    logic                      w_center;
    logic                      w_wr_en;
    logic [SW-1:0]             w_wr_idx;
    logic [CW-1:0]             w_wr_x;
    logic [CW-1:0]             w_wr_y;
    logic [SW-1:0]             w_rd_next;

    mcg_neighbor_check #(
        .BOARD_N (BOARD_N),
        .RADIUS  (RADIUS)
    ) u_nbr (
        .i_board (r_board),
        .i_x     (r_x),
        .i_y     (r_y),
        .o_cand  (w_cand)
    );

    assign w_last_cell = (r_x == LAST_C) && (r_y == LAST_C);
    assign w_rd_next   = r_rd + 1'b1;

`ifdef MCG_EMPTY_CENTER_EN
    localparam int IW = $clog2(2*BOARD_N*BOARD_N);

    logic          r_stone_seen;
    logic [IW-1:0] w_idx;
    logic          w_cell_empty;

    assign w_idx        = IW'(2*(int'(r_y)*BOARD_N + int'(r_x)));
    assign w_cell_empty = (r_board[w_idx +: 2] == CELL_EMPTY);
    // No stone anywhere, including the cell being scanned on the last cycle.
    assign w_center     = (r_state == ST_SCAN) && w_last_cell && !r_stone_seen && w_cell_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stone_seen <= 1'b0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_stone_seen <= 1'b0;
        end else if (r_state == ST_SCAN && !w_cell_empty) begin
            r_stone_seen <= 1'b1;
        end
    end
`else
    assign w_center = 1'b0;
`endif

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_size;
        w_wr_x   = r_x;
        w_wr_y   = r_y;
        if (w_center) begin
            w_wr_en  = 1'b1;
            w_wr_idx = '0;
            w_wr_x   = CENTER;
            w_wr_y   = CENTER;
        end else if (r_state == ST_SCAN && w_cand && r_size < MAX_S) begin
            w_wr_en  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_buf_x[w_wr_idx] <= w_wr_x;
            r_buf_y[w_wr_idx] <= w_wr_y;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_board    <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_size     <= '0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_posX     <= '0;
            r_posY     <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_board    <= i_board;
                        r_size     <= '0;
                        r_overflow <= 1'b0;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_wr_en) begin
                        r_size <= r_size + 1'b1;
                    end else if (w_cand) begin
                        r_overflow <= 1'b1;
                    end
                    if (r_x == LAST_C) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                    if (w_last_cell) begin
                        r_x <= '0;
                        r_y <= '0;
                        if (r_size != '0 || w_wr_en) begin
                            r_rd    <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_finish <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // First DRAIN cycle loads entry 0; afterwards each acceptance
                    // loads the following entry directly.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_posX  <= r_buf_x[r_rd];
                        r_posY  <= r_buf_y[r_rd];
                        r_last  <= (r_rd == r_size - 1'b1);
                    end else if (i_ready) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_finish <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_rd    <= w_rd_next;
                            r_posX  <= r_buf_x[w_rd_next];
                            r_posY  <= r_buf_y[w_rd_next];
                            r_last  <= (w_rd_next == r_size - 1'b1);
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_valid    = r_valid;
    assign o_posX     = r_posX;
    assign o_posY     = r_posY;
    assign o_last     = r_last;
    assign o_size     = r_size;
    assign o_overflow = r_overflow;
    assign o_busy     = r_busy;
    assign o_finish   = r_finish;

endmodule
